// File: rtl/systolic_psum_accumulator_if.sv
// Handshake and control bundle between a partial-sum producer/consumer and the accumulator.
interface systolic_psum_accumulator_if #(
  parameter int unsigned N_SIZE     = 32,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned ROWS       = 512,
  parameter int unsigned ADDR_WIDTH = $clog2(ROWS),
  parameter int unsigned MAX_KTILES = 16,
  parameter int unsigned KT_WIDTH   = $clog2(MAX_KTILES) + 1
);
  logic                          start;
  logic [ADDR_WIDTH:0]           num_rows;
  logic [KT_WIDTH-1:0]           num_ktiles;
  logic                          in_valid;
  logic [N_SIZE*ACC_WIDTH-1:0]   in_data;
  logic                          in_ready;
  logic                          out_valid;
  logic [N_SIZE*ACC_WIDTH-1:0]   out_data;
  logic                          out_last;
  logic                          out_ready;
  logic                          busy;
  logic                          done;
  logic                          sat_flag;

  modport master (
    output start, num_rows, num_ktiles, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, done, sat_flag
  );

  modport slave (
    input  start, num_rows, num_ktiles, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, done, sat_flag
  );
endinterface

// File: rtl/systolic_psum_accumulator.sv
// Accumulates K-tiles of systolic partial-sum rows into a row buffer with
// per-lane signed saturation, then drains the tile row by row.
module systolic_psum_accumulator #(
  parameter int unsigned N_SIZE     = 32,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned ROWS       = 512,
  parameter int unsigned ADDR_WIDTH = $clog2(ROWS),
  parameter int unsigned MAX_KTILES = 16,
  parameter int unsigned KT_WIDTH   = $clog2(MAX_KTILES) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  systolic_psum_accumulator_if.slave bus
);
  localparam int unsigned DW = N_SIZE * ACC_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   num_rows_q, num_rows_d;
  logic [KT_WIDTH-1:0]   num_kt_q, num_kt_d;
  logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [KT_WIDTH-1:0]   k_cnt_q, k_cnt_d;
  logic [ADDR_WIDTH-1:0] drain_row_q, drain_row_d;
  logic                  sat_q, sat_d;
  logic [DW-1:0]         out_data_q, out_data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DW-1:0]         mem [ROWS];
  logic [DW-1:0]         mem_rd_c;
  logic [DW-1:0]         sat_data_c;
  logic [DW-1:0]         wr_data_c;
  logic                  sat_any_c;
  logic                  mem_we_c;
  logic [ACC_WIDTH:0]    lane_sum_c [N_SIZE];
  logic [ADDR_WIDTH-1:0] last_row_c;
  logic [KT_WIDTH-1:0]   last_k_c;

  assign mem_rd_c   = mem[row_cnt_q];
  assign last_row_c = ADDR_WIDTH'(num_rows_q - 1'b1);
  assign last_k_c   = num_kt_q - 1'b1;

  // Per-lane signed add at one extra bit, clamped to the ACC_WIDTH range.
  always_comb begin
    sat_any_c  = 1'b0;
    sat_data_c = '0;
    for (int i = 0; i < N_SIZE; i++) begin
      lane_sum_c[i] = {mem_rd_c[i*ACC_WIDTH+ACC_WIDTH-1], mem_rd_c[i*ACC_WIDTH +: ACC_WIDTH]}
                    + {bus.in_data[i*ACC_WIDTH+ACC_WIDTH-1], bus.in_data[i*ACC_WIDTH +: ACC_WIDTH]};
      if (lane_sum_c[i][ACC_WIDTH] != lane_sum_c[i][ACC_WIDTH-1]) begin
        sat_any_c = 1'b1;
        sat_data_c[i*ACC_WIDTH +: ACC_WIDTH] = lane_sum_c[i][ACC_WIDTH]
          ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        sat_data_c[i*ACC_WIDTH +: ACC_WIDTH] = lane_sum_c[i][ACC_WIDTH-1:0];
      end
    end
  end

  assign wr_data_c = (k_cnt_q == '0) ? bus.in_data : sat_data_c;

  always_comb begin
    state_d     = state_q;
    num_rows_d  = num_rows_q;
    num_kt_d    = num_kt_q;
    row_cnt_d   = row_cnt_q;
    k_cnt_d     = k_cnt_q;
    drain_row_d = drain_row_q;
    sat_d       = sat_q;
    out_data_d  = out_data_q;
    mem_we_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_rows_d = (bus.num_rows > (ADDR_WIDTH+1)'(ROWS)) ? (ADDR_WIDTH+1)'(ROWS) : bus.num_rows;
          if (bus.num_ktiles == '0)                         num_kt_d = KT_WIDTH'(1);
          else if (bus.num_ktiles > KT_WIDTH'(MAX_KTILES))  num_kt_d = KT_WIDTH'(MAX_KTILES);
          else                                              num_kt_d = bus.num_ktiles;
          row_cnt_d = '0;
          k_cnt_d   = '0;
          sat_d     = 1'b0;
          state_d   = (bus.num_rows == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus.in_valid) begin
          mem_we_c = 1'b1;
          if (k_cnt_q != '0 && sat_any_c) sat_d = 1'b1;
          if (row_cnt_q == last_row_c) begin
            row_cnt_d = '0;
            k_cnt_d   = k_cnt_q + 1'b1;
            if (k_cnt_q == last_k_c) begin
              state_d     = S_DRAIN;
              drain_row_d = '0;
              // Single-row tile: row 0 is being written on this same edge.
              out_data_d  = (last_row_c == '0) ? wr_data_c : mem[0];
            end
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (drain_row_q == last_row_c) begin
            state_d = S_DONE;
          end else begin
            drain_row_d = drain_row_q + 1'b1;
            out_data_d  = mem[ADDR_WIDTH'(drain_row_q + 1'b1)];
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_ACCUM);
    out_valid_d = (state_d == S_DRAIN);
    out_last_d  = (state_d == S_DRAIN) && (drain_row_d == last_row_c);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      num_rows_q  <= '0;
      num_kt_q    <= '0;
      row_cnt_q   <= '0;
      k_cnt_q     <= '0;
      drain_row_q <= '0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_rows_q  <= num_rows_d;
      num_kt_q    <= num_kt_d;
      row_cnt_q   <= row_cnt_d;
      k_cnt_q     <= k_cnt_d;
      drain_row_q <= drain_row_d;
      sat_q       <= sat_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Row buffer has no reset; contents are only exposed through a fresh drain.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) mem[row_cnt_q] <= wr_data_c;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_systolic_psum_accumulator.sv
// Randomized bench for systolic_psum_accumulator against a saturating-sum row model.
module tb_systolic_psum_accumulator;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned RW = 8;
  localparam int unsigned MK = 4;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } row_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  row_t        exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] dir_beats [16];

  systolic_psum_accumulator_if #(.N_SIZE(N), .ACC_WIDTH(AW), .ROWS(RW), .MAX_KTILES(MK)) bus ();

  systolic_psum_accumulator #(.N_SIZE(N), .ACC_WIDTH(AW), .ROWS(RW), .MAX_KTILES(MK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drained rows are compared against the model queue in order.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1'b1, 1'b0);
      end else begin
        chk("out_data", bus.out_data, exp_q[0].data);
        chk("out_last", bus.out_last, exp_q[0].last);
        if (bus.out_ready) begin
          got_q.push_back(bus.out_data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_pass(input int nr, input int nk, input int mode, input bit stall, input bit junk);
    int          ek;
    int          acc [8][4];
    bit          sat;
    int          s;
    int          guard;
    byte         b;
    logic [31:0] beat;
    logic [31:0] packed_row;
    ek  = (nk == 0) ? 1 : (nk > int'(MK)) ? int'(MK) : nk;
    sat = 1'b0;
    got_q.delete();
    bus.start      = 1'b1;
    bus.num_rows   = 4'(nr);
    bus.num_ktiles = 3'(nk);
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1'b1);
    chk("sat_clear_on_start", bus.sat_flag, 1'b0);
    if (nr == 0) begin
      chk("zero_rows_in_ready", bus.in_ready, 1'b0);
      chk("zero_rows_out_valid", bus.out_valid, 1'b0);
      chk("zero_rows_done", bus.done, 1'b1);
      tick();
      chk("zero_rows_done_clear", bus.done, 1'b0);
      chk("zero_rows_idle", bus.busy, 1'b0);
      return;
    end
    for (int k = 0; k < ek; k++) begin
      for (int r = 0; r < nr; r++) begin
        if (mode == 2) begin
          beat = dir_beats[k*nr + r];
        end else begin
          for (int l = 0; l < int'(N); l++)
            beat[l*8 +: 8] = (mode == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40) - 20);
        end
        if ($urandom_range(0, 3) == 0) begin
          bus.in_valid  = 1'b0;
          bus.in_data   = $urandom;
          bus.out_ready = 1'($urandom_range(0, 1));
          chk("in_ready_idle_gap", bus.in_ready, 1'b1);
          tick();
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = beat;
        bus.out_ready = 1'($urandom_range(0, 1));
        if (junk && k == 0 && r == 0) begin
          bus.start    = 1'b1;
          bus.num_rows = 4'd0;
        end
        chk("in_ready_accum", bus.in_ready, 1'b1);
        tick();
        bus.start = 1'b0;
        chk("busy_accum", bus.busy, 1'b1);
        for (int l = 0; l < int'(N); l++) begin
          b = beat[l*8 +: 8];
          if (k == 0) begin
            acc[r][l] = b;
          end else begin
            s = acc[r][l] + b;
            if (s > 127)  begin s = 127;  sat = 1'b1; end
            if (s < -128) begin s = -128; sat = 1'b1; end
            acc[r][l] = s;
          end
        end
      end
    end
    bus.in_valid = 1'b0;
    for (int r = 0; r < nr; r++) begin
      for (int l = 0; l < int'(N); l++) packed_row[l*8 +: 8] = 8'(acc[r][l]);
      exp_q.push_back('{data: packed_row, last: (r == nr - 1)});
    end
    chk("in_ready_drain", bus.in_ready, 1'b0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      bus.out_ready = stall ? (guard % 2 == 1) : 1'b1;
      tick();
      guard++;
      chk("busy_drain", bus.busy, 1'b1);
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout_rows_left", exp_q.size(), 0);
      exp_q.delete();
    end
    bus.out_ready = 1'b0;
    chk("done_pulse", bus.done, 1'b1);
    chk("sat_flag_pass", bus.sat_flag, sat);
    tick();
    chk("done_clear", bus.done, 1'b0);
    chk("idle_not_busy", bus.busy, 1'b0);
    chk("sat_flag_hold", bus.sat_flag, sat);
    chk("rows_drained", got_q.size(), nr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.num_rows = '0; bus.num_ktiles = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_out_data", bus.out_data, 32'h0);
    rst_n = 1'b1;
    tick();

    // Two rows, one K-tile: rows pass through unchanged.
    dir_beats[0] = 32'h04030201;
    dir_beats[1] = 32'h08070605;
    run_pass(2, 1, 2, 1'b0, 1'b0);
    chk("lit_row0", got_q[0], 32'h04030201);
    chk("lit_row1", got_q[1], 32'h08070605);

    // Three K-tiles of all-10 lanes sum to 30.
    for (int i = 0; i < 9; i++) dir_beats[i] = 32'h0A0A0A0A;
    run_pass(3, 3, 2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) chk("lit_sum30", got_q[i], 32'h1E1E1E1E);

    // Lane0 100+100 clamps to 127, lane1 -100-100 clamps to -128.
    dir_beats[0] = 32'h00009C64;
    dir_beats[1] = 32'h00009C64;
    run_pass(1, 2, 2, 1'b0, 1'b0);
    chk("lit_sat_row", got_q[0], 32'h0000807F);
    chk("lit_sat_flag", bus.sat_flag, 1'b1);

    // Zero-row pass and stalled drain.
    run_pass(0, 1, 0, 1'b0, 1'b0);
    run_pass(5, 2, 0, 1'b1, 1'b1);
    run_pass(8, 6, 1, 1'b1, 1'b0);
    run_pass(2, 0, 1, 1'b0, 1'b0);

    // Reset in the middle of accumulation.
    bus.start = 1'b1; bus.num_rows = 4'd3; bus.num_ktiles = 3'd2;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 32'h7F7F7F7F;
    tick();
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("midrst_in_ready", bus.in_ready, 1'b0);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_out_last", bus.out_last, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_sat", bus.sat_flag, 1'b0);
    chk("midrst_out_data", bus.out_data, 32'h0);
    rst_n = 1'b1;
    tick();
    run_pass(1, 1, 1, 1'b0, 1'b0);

    for (int p = 0; p < 20; p++)
      run_pass($urandom_range(1, 8), $urandom_range(0, 6), $urandom_range(0, 1),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
